dragster_spi_responder: RTL and testbench
=========================================

Name: dragster_spi_responder

Overview:
- SPI slave model of the Dragster linear sensor's register interface; the far end of the sensor SPI link driven by dragster_configurator.
- Used in configurator benches and FPGA loopback builds in place of the real sensor. Decodes write/read frames into a small register file and returns read data on miso.
- Oversamples sclk, mosi and ss_n in the system clock domain; contains no sclk-clocked logic.

Parameters:
- SS_INDEX, 0, bit of ss_n that selects this device (0 or 1)
- ADDR_WIDTH, 7, register address bits in the command byte
- DATA_WIDTH, 8, register data bits
- REG_COUNT, 16, implemented registers at addresses 0..REG_COUNT-1
- SYNC_STAGES, 2, synchronizer depth on sclk, mosi and ss_n

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  synchronous, active-low reset
- sclk  in  1  SPI clock from the master, asynchronous to clk
- mosi  in  1  master-out data
- ss_n  in  2  active-low slave selects; only ss_n[SS_INDEX] is used
- miso  out  1  slave-out data
- miso_oe  out  1  high while this device is selected
- reg_wr_strobe  out  1  one-cycle pulse per completed write frame
- reg_wr_addr  out  ADDR_WIDTH  address of the completed write
- reg_wr_data  out  DATA_WIDTH  data of the completed write
- frame_error  out  1  one-cycle pulse on an aborted or invalid frame
- dbg_addr  in  ADDR_WIDTH  host-side register readout address
- dbg_data  out  DATA_WIDTH  register at dbg_addr, registered, 1-cycle latency

Behaviour:
- Reset, while reset_n=0 at a clk edge:
  - all registers = 0; state = IDLE
  - miso=0, miso_oe=0, reg_wr_strobe=0, reg_wr_addr=0, reg_wr_data=0, frame_error=0, dbg_data=0
- Synchronization and edge detection:
  - sclk, mosi and ss_n[SS_INDEX] each pass through SYNC_STAGES flops.
  - Rise and fall are detected on the synchronized sclk.
  - Input-to-action latency is SYNC_STAGES+1 clk.
  - Each sclk phase must be at least 4 clk long.
- Protocol: SPI mode 0, MSB first, 16-bit frame.
  - Bit 15 is R/W: 1 = write, 0 = read.
  - Bits 14:8 are the address; bits 7:0 are data.
  - mosi is sampled on the sclk rise.
- States:
  - IDLE: on synchronized ss_n falling to 0 -> CMD, bit counter cleared.
  - CMD: shifts in 8 bits. After the 8th rise: write -> WR_DATA. Read -> loads the addressed register (0 if addr >= REG_COUNT) into the tx shifter, drives its MSB on miso in the same cycle, -> RD_DATA.
  - WR_DATA: shifts in 8 bits. On the 8th rise:
    - addr < REG_COUNT: register updated; reg_wr_strobe pulses with addr/data on the next clk.
    - addr >= REG_COUNT: no update, no strobe, frame_error pulses.
    - Then -> DONE.
  - RD_DATA: miso advances one bit on each sclk fall. After the 8th data rise -> DONE.
  - DONE: further sclk edges are ignored; miso=0. On ss_n high -> IDLE.
- ss_n rising in CMD, WR_DATA or RD_DATA (mid-frame abort):
  - frame_error pulses 1 clk; no register write; -> IDLE.
  - A rise in IDLE or DONE is not an error.
- miso_oe equals the synchronized select. miso is 0 whenever miso_oe=0 or the state is not RD_DATA.
- Simultaneous events:
  - An internal reg write and a dbg_addr read of the same address in the same clk: dbg_data shows the old value that cycle and the new value the next cycle.
  - Reset asserted mid-frame clears everything; a select still held low after reset does not start a frame until ss_n goes high and then low again.
- Bit counters are 4 bits, saturating; no wrap within a frame.

Test Plan:
- Reset then idle: reset_n low 3 clk -> all outputs 0; dbg_addr=0..15 returns 0x00 each.
- Write frame 0x8A5C (addr 0x0A, data 0x5C), sclk=clk/8 -> one reg_wr_strobe with addr=0x0A, data=0x5C; dbg_addr=0x0A gives 0x5C one clk later; frame_error stays 0.
- Read after write, frame 0x0A00 -> miso shifts 0,1,0,1,1,1,0,0 on the 8 data rises; miso_oe=1 throughout; no strobe.
- Out-of-range write 0xC0FF (addr 0x40) -> no strobe, frame_error one pulse; a read of 0x40 returns 0x00.
- Abort: ss_n rises after 11 bits of 0x8312 -> frame_error pulse, register 3 unchanged; a following full 0x8312 writes 0x12.
- Select isolation: SS_INDEX=0, frame on ss_n[1] only -> miso=0, miso_oe=0, no strobe, no register change.

Source files
------------

// File: rtl/dragster_spi_responder.sv
// SPI mode-0 slave standing in for the Dragster sensor register interface.
// All SPI inputs are oversampled in the clk domain; no logic is clocked by sclk.
module dragster_spi_responder #(
   parameter int SS_INDEX    = 0,
   parameter int ADDR_WIDTH  = 7,
   parameter int DATA_WIDTH  = 8,
   parameter int REG_COUNT   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclk,
   input  logic                  mosi,
   input  logic [1:0]            ss_n,
   output logic                  miso,
   output logic                  miso_oe,
   output logic                  reg_wr_strobe,
   output logic [ADDR_WIDTH-1:0] reg_wr_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   output logic                  frame_error,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic [2:0]            dbg_state
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [ADDR_WIDTH:0] LP_REG_COUNT = (ADDR_WIDTH+1)'(REG_COUNT);
   localparam logic [3:0] LP_CMD_LAST  = 4'(ADDR_WIDTH);
   localparam logic [3:0] LP_DATA_LAST = 4'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_WR_DATA = 3'd2,
      S_RD_DATA = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t r_state, w_next_state;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
   logic                   r_sclk_prev, r_ss_prev, r_armed;
   logic [3:0]             r_bit_cnt;
   logic [ADDR_WIDTH-1:0]  r_cmd_shift, r_addr;
   logic [DATA_WIDTH-2:0]  r_data_shift;
   logic [DATA_WIDTH-1:0]  r_tx;
   logic [DATA_WIDTH-1:0]  r_regs [REG_COUNT];
   logic                   r_wr_strobe, r_frame_error;
   logic [ADDR_WIDTH-1:0]  r_wr_addr;
   logic [DATA_WIDTH-1:0]  r_wr_data, r_dbg_data;

   logic w_sclk, w_mosi, w_ss_n;
   logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
   logic w_selected, w_bit_rise;
   logic w_abort, w_cmd_last, w_wr_last;
   logic [ADDR_WIDTH:0]   w_cmd_byte;
   logic [ADDR_WIDTH-1:0] w_cmd_addr;
   logic                  w_cmd_rw, w_cmd_addr_ok, w_addr_ok;
   logic [DATA_WIDTH-1:0] w_wr_byte;
   logic                  w_unused_ss;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return {1'b0, a} < LP_REG_COUNT;
   endfunction

   assign w_unused_ss = &{1'b0, ss_n};

   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_n = r_ss_sync[SYNC_STAGES-1];

   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk & r_sclk_prev;
   // ss edges only count from real samples: the chain resets to "low", so a
   // select held low through reset never produces a fall.
   assign w_ss_rise   = w_ss_n & ~r_ss_prev;
   assign w_ss_fall   = ~w_ss_n & r_ss_prev;

   assign w_selected  = ~w_ss_n & r_armed;
   assign w_bit_rise  = w_sclk_rise & ~w_ss_rise &
                        (r_state inside {S_CMD, S_WR_DATA, S_RD_DATA});

   assign w_cmd_byte    = {r_cmd_shift, w_mosi};
   assign w_cmd_addr    = w_cmd_byte[ADDR_WIDTH-1:0];
   assign w_cmd_rw      = w_cmd_byte[ADDR_WIDTH];
   assign w_cmd_addr_ok = in_range(w_cmd_addr);
   assign w_addr_ok     = in_range(r_addr);
   assign w_wr_byte     = {r_data_shift, w_mosi};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_ss_sync   <= '0;
         r_sclk_prev <= 1'b0;
         r_ss_prev   <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n[SS_INDEX]};
         r_sclk_prev <= w_sclk;
         r_ss_prev   <= w_ss_n;
         if (w_ss_n) r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_abort      = 1'b0;
      w_cmd_last   = 1'b0;
      w_wr_last    = 1'b0;
      case (r_state)
         S_IDLE: if (w_ss_fall) w_next_state = S_CMD;
         S_CMD: begin
            if (w_ss_rise) begin
               w_abort      = 1'b1;
               w_next_state = S_IDLE;
            end else if (w_sclk_rise && r_bit_cnt == LP_CMD_LAST) begin
               w_cmd_last   = 1'b1;
               w_next_state = w_cmd_rw ? S_WR_DATA : S_RD_DATA;
            end
         end
         S_WR_DATA: begin
            if (w_ss_rise) begin
               w_abort      = 1'b1;
               w_next_state = S_IDLE;
            end else if (w_sclk_rise && r_bit_cnt == LP_DATA_LAST) begin
               w_wr_last    = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_RD_DATA: begin
            if (w_ss_rise) begin
               w_abort      = 1'b1;
               w_next_state = S_IDLE;
            end else if (w_sclk_rise && r_bit_cnt == LP_DATA_LAST) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: if (w_ss_rise) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_bit_cnt     <= '0;
         r_cmd_shift   <= '0;
         r_data_shift  <= '0;
         r_addr        <= '0;
         r_tx          <= '0;
         r_wr_strobe   <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= '0;
         r_frame_error <= 1'b0;
         r_dbg_data    <= '0;
         for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      end else begin
         r_wr_strobe   <= 1'b0;
         r_frame_error <= w_abort | (w_wr_last & ~w_addr_ok);
         r_dbg_data    <= in_range(dbg_addr) ? r_regs[dbg_addr[IDX_W-1:0]] : '0;

         if (r_state == S_IDLE && w_ss_fall) r_bit_cnt <= '0;

         if (w_cmd_last) begin
            r_bit_cnt <= '0;
            r_addr    <= w_cmd_addr;
            r_tx      <= (!w_cmd_rw && w_cmd_addr_ok) ? r_regs[w_cmd_addr[IDX_W-1:0]] : '0;
         end else if (w_wr_last) begin
            if (w_addr_ok) begin
               r_regs[r_addr[IDX_W-1:0]] <= w_wr_byte;
               r_wr_strobe <= 1'b1;
               r_wr_addr   <= r_addr;
               r_wr_data   <= w_wr_byte;
            end
         end else if (w_bit_rise) begin
            if (r_bit_cnt != 4'hF) r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_state == S_CMD)     r_cmd_shift  <= w_cmd_byte[ADDR_WIDTH-1:0];
            if (r_state == S_WR_DATA) r_data_shift <= w_wr_byte[DATA_WIDTH-2:0];
         end

         // The MSB is already on miso when the read turns around, so the fall
         // that follows the last command bit must not shift it away.
         if (r_state == S_RD_DATA && w_sclk_fall && r_bit_cnt != 4'd0)
            r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign miso          = (r_state == S_RD_DATA) & w_selected & r_tx[DATA_WIDTH-1];
   assign miso_oe       = w_selected;
   assign reg_wr_strobe = r_wr_strobe;
   assign reg_wr_addr   = r_wr_addr;
   assign reg_wr_data   = r_wr_data;
   assign frame_error   = r_frame_error;
   assign dbg_data      = r_dbg_data;
   assign dbg_state     = r_state;

endmodule

// File: tb/tb_dragster_spi_responder.sv
// Directed bench for dragster_spi_responder: bit-banged SPI frames at sclk = clk/8
// with hand-computed expectations for strobes, errors, miso and the debug port.
module tb_dragster_spi_responder;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sclk;
   logic       mosi;
   logic [1:0] ss_n;
   logic       miso;
   logic       miso_oe;
   logic       reg_wr_strobe;
   logic [6:0] reg_wr_addr;
   logic [7:0] reg_wr_data;
   logic       frame_error;
   logic [6:0] dbg_addr;
   logic [7:0] dbg_data;
   logic [2:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   int         strobe_cycles = 0;
   int         err_cycles    = 0;
   int         err_pulses    = 0;
   logic       err_prev      = 1'b0;
   bit         cap_pending   = 1'b0;
   logic [6:0] cap_addr      = '0;
   logic [7:0] cap_data      = '0;
   logic [7:0] cap_dbg_at    = '0;
   logic [7:0] cap_dbg_next  = '0;

   logic [7:0] rx_byte;
   int         oe_cnt;
   logic       miso_or;
   logic [7:0] rd;
   int         s0, e0, c0;

   dragster_spi_responder #(
      .SS_INDEX(0), .ADDR_WIDTH(7), .DATA_WIDTH(8), .REG_COUNT(16), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
      .miso(miso), .miso_oe(miso_oe), .reg_wr_strobe(reg_wr_strobe),
      .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .frame_error(frame_error),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Event monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (reg_wr_strobe === 1'b1) begin
         strobe_cycles++;
         cap_addr    = reg_wr_addr;
         cap_data    = reg_wr_data;
         cap_dbg_at  = dbg_data;
         cap_pending = 1'b1;
      end else if (cap_pending) begin
         cap_dbg_next = dbg_data;
         cap_pending  = 1'b0;
      end
      if (frame_error === 1'b1) begin
         err_cycles++;
         if (!err_prev) err_pulses++;
      end
      err_prev = (frame_error === 1'b1);
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dbg_read(input logic [6:0] a, output logic [7:0] d);
      @(posedge clk);
      #1;
      dbg_addr = a;
      @(posedge clk);
      @(negedge clk);
      d = dbg_data;
   endtask

   // Clocks nbits of frame (MSB first) on ss_n[sel]; samples miso just before
   // each rise, collecting the bits seen on rises 9..16 into rx_byte.
   task automatic spi_frame(input logic [15:0] frame, input int nbits, input int sel,
                            input bit release_ss);
      rx_byte = '0;
      oe_cnt  = 0;
      miso_or = 1'b0;
      ss_n[sel] = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         mosi = frame[15-i];
         wait_clk(3);
         @(negedge clk);
         if (i >= 8) rx_byte = {rx_byte[6:0], miso};
         miso_or = miso_or | miso;
         if (miso_oe === 1'b1) oe_cnt++;
         wait_clk(1);
         sclk = 1'b1;
         wait_clk(4);
         sclk = 1'b0;
      end
      wait_clk(4);
      if (release_ss) begin
         ss_n = 2'b11;
         wait_clk(6);
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      sclk     = 1'b0;
      mosi     = 1'b0;
      ss_n     = 2'b11;
      dbg_addr = '0;

      // Reset then idle
      wait_clk(3);
      @(negedge clk);
      check_eq("rst_flags", {12'd0, miso, miso_oe, reg_wr_strobe, frame_error}, 16'h0);
      check_eq("rst_wr_addr", {9'd0, reg_wr_addr}, 16'h0);
      check_eq("rst_wr_data", {8'd0, reg_wr_data}, 16'h0);
      check_eq("rst_dbg_data", {8'd0, dbg_data}, 16'h0);
      check_eq("rst_state", {13'd0, dbg_state}, 16'h0);
      wait_clk(1);
      reset_n = 1'b1;
      wait_clk(6);
      for (int a = 0; a < 16; a++) begin
         dbg_read(7'(a), rd);
         check_eq("dbg_after_rst", {8'd0, rd}, 16'h0);
      end
      check_eq("idle_no_err", 16'(err_pulses), 16'd0);

      // Write 0x5C to 0x0A
      s0 = strobe_cycles; e0 = err_pulses;
      spi_frame(16'h8A5C, 16, 0, 1'b1);
      check_eq("wr_strobe_cnt", 16'(strobe_cycles - s0), 16'd1);
      check_eq("wr_addr", {9'd0, cap_addr}, 16'h000A);
      check_eq("wr_data", {8'd0, cap_data}, 16'h005C);
      check_eq("wr_no_err", 16'(err_pulses - e0), 16'd0);
      dbg_read(7'h0A, rd);
      check_eq("wr_dbg", {8'd0, rd}, 16'h005C);

      // Read back 0x0A
      s0 = strobe_cycles;
      spi_frame(16'h0A00, 16, 0, 1'b1);
      check_eq("rd_miso_byte", {8'd0, rx_byte}, 16'h005C);
      check_eq("rd_oe_cnt", 16'(oe_cnt), 16'd16);
      check_eq("rd_no_strobe", 16'(strobe_cycles - s0), 16'd0);

      // Out-of-range write, then read of the same address
      s0 = strobe_cycles; e0 = err_pulses; c0 = err_cycles;
      spi_frame(16'hC0FF, 16, 0, 1'b1);
      check_eq("oor_no_strobe", 16'(strobe_cycles - s0), 16'd0);
      check_eq("oor_err_pulses", 16'(err_pulses - e0), 16'd1);
      check_eq("oor_err_width", 16'(err_cycles - c0), 16'd1);
      spi_frame(16'h4000, 16, 0, 1'b1);
      check_eq("oor_rd_byte", {8'd0, rx_byte}, 16'h0000);
      check_eq("oor_rd_oe", 16'(oe_cnt), 16'd16);

      // Abort after 11 bits, then a complete write of the same frame
      s0 = strobe_cycles; e0 = err_pulses;
      spi_frame(16'h8312, 11, 0, 1'b1);
      check_eq("abort_err", 16'(err_pulses - e0), 16'd1);
      check_eq("abort_no_strobe", 16'(strobe_cycles - s0), 16'd0);
      dbg_read(7'h03, rd);
      check_eq("abort_reg3", {8'd0, rd}, 16'h0000);
      s0 = strobe_cycles; e0 = err_pulses;
      spi_frame(16'h8312, 16, 0, 1'b1);
      check_eq("wr3_strobe", 16'(strobe_cycles - s0), 16'd1);
      check_eq("wr3_addr", {9'd0, cap_addr}, 16'h0003);
      check_eq("wr3_data", {8'd0, cap_data}, 16'h0012);
      check_eq("wr3_no_err", 16'(err_pulses - e0), 16'd0);
      check_eq("wr3_dbg_old", {8'd0, cap_dbg_at}, 16'h0000);
      check_eq("wr3_dbg_new", {8'd0, cap_dbg_next}, 16'h0012);

      // Frame addressed to the other select line
      s0 = strobe_cycles; e0 = err_pulses;
      spi_frame(16'h8A77, 16, 1, 1'b1);
      check_eq("iso_oe", 16'(oe_cnt), 16'd0);
      check_eq("iso_miso", {15'd0, miso_or}, 16'd0);
      check_eq("iso_no_strobe", 16'(strobe_cycles - s0), 16'd0);
      check_eq("iso_no_err", 16'(err_pulses - e0), 16'd0);
      dbg_read(7'h0A, rd);
      check_eq("iso_reg_kept", {8'd0, rd}, 16'h005C);

      // Reset mid-frame with the select held low throughout
      spi_frame(16'h8555, 6, 0, 1'b0);
      reset_n = 1'b0;
      wait_clk(3);
      @(negedge clk);
      check_eq("midrst_oe", {15'd0, miso_oe}, 16'd0);
      check_eq("midrst_state", {13'd0, dbg_state}, 16'd0);
      wait_clk(1);
      reset_n = 1'b1;
      s0 = strobe_cycles; e0 = err_pulses;
      spi_frame(16'h8555, 16, 0, 1'b1);
      check_eq("held_sel_no_strobe", 16'(strobe_cycles - s0), 16'd0);
      check_eq("held_sel_no_err", 16'(err_pulses - e0), 16'd0);
      dbg_read(7'h05, rd);
      check_eq("held_sel_reg5", {8'd0, rd}, 16'h0000);
      dbg_read(7'h0A, rd);
      check_eq("midrst_cleared", {8'd0, rd}, 16'h0000);
      s0 = strobe_cycles;
      spi_frame(16'h8555, 16, 0, 1'b1);
      check_eq("post_rst_strobe", 16'(strobe_cycles - s0), 16'd1);
      dbg_read(7'h05, rd);
      check_eq("post_rst_reg5", {8'd0, rd}, 16'h0055);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
